// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and the coordinate type used by the
// timing generator and by the pixel-colour blocks (field, paddles, ball, score).
package vga_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

  localparam int H_SYNC_START = H_ACTIVE + H_FP;             // 656
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;       // 752
  localparam int V_SYNC_START = V_ACTIVE + V_FP;             // 490
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;       // 492

  // 0 = sync pulses are active-low
  localparam logic SYNC_POL = 1'b0;

  // Half-open interval test [lo, hi)
  function automatic logic in_range(coord_t x, coord_t lo, coord_t hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_mod_counter.sv
// Generic modulo-N counter with enable, terminal-count flag and synchronous reset.
// count_next is exported so callers can register decodes of the upcoming value.
module mod_counter #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  // High while sitting on the last value, regardless of en
  assign wrap = (count == LAST);

  // NOTE: default assigned first so every path drives count_next; no latch.
  always_comb begin
    count_next = count;
    if (en) count_next = wrap ? '0 : count + W'(1);
  end

  // NOTE: state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count_next;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: beam position, syncs, blank and a per-frame tick.
// Define CLK_DIV_EN when clk is 50 MHz to derive the 25 MHz pixel strobe internally.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_pkg::H_FP,
  parameter int   H_SYNC   = vga_pkg::H_SYNC,
  parameter int   H_BP     = vga_pkg::H_BP,
  parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_pkg::V_FP,
  parameter int   V_SYNC   = vga_pkg::V_SYNC,
  parameter int   V_BP     = vga_pkg::V_BP,
  parameter logic SYNC_POL = vga_pkg::SYNC_POL
) (
  input  logic   clk,
  input  logic   rst,
  output logic   pix_tick,
  output coord_t pos_h,
  output coord_t pos_v,
  output logic   hsync,
  output logic   vsync,
  output logic   blank,
  output logic   frame_tick
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOT > 1023 || V_TOT > 1023) begin : g_bad_totals
    $error("vga_timing_gen: line/frame totals exceed the 10-bit counter range");
  end

`ifdef CLK_DIV_EN
  logic phase;

  always_ff @(posedge clk) begin
    if (rst) phase <= 1'b0;
    else     phase <= ~phase;
  end

  assign pix_tick = phase;
`else
  assign pix_tick = 1'b1;
`endif

  coord_t h_next, v_next;
  logic   h_wrap;
  logic   unused_v_wrap;

  mod_counter #(.N(H_TOT), .W(COORD_W)) u_h_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (pix_tick),
    .count      (pos_h),
    .count_next (h_next),
    .wrap       (h_wrap)
  );

  mod_counter #(.N(V_TOT), .W(COORD_W)) u_v_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (pix_tick && h_wrap),
    .count      (pos_v),
    .count_next (v_next),
    .wrap       (unused_v_wrap)
  );

  // Decoding the next count keeps flags aligned with pos_h/pos_v on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      blank      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      hsync      <= in_range(h_next, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync      <= in_range(v_next, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
      blank      <= (h_next >= H_VIS) || (v_next >= V_VIS);
      frame_tick <= (h_next == '0) && (v_next == V_VIS);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for line timing and reset, plus a
// tiny-raster instance (active-high syncs) so whole frames fit in a short run.
module tb_vga_timing_gen;

`ifdef CLK_DIV_EN
  localparam bit DIV = 1'b1;
`else
  localparam bit DIV = 1'b0;
`endif

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit pol;
  } tparam_t;

  typedef struct {
    int h;
    int v;
    bit ph;
  } mstate_t;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic       rst_a, rst_b;
  logic       pix_tick_a, hsync_a, vsync_a, blank_a, frame_tick_a;
  logic       pix_tick_b, hsync_b, vsync_b, blank_b, frame_tick_b;
  logic [9:0] pos_h_a, pos_v_a, pos_h_b, pos_v_b;

  vga_timing_gen u_dut_a (
    .clk(clk), .rst(rst_a), .pix_tick(pix_tick_a), .pos_h(pos_h_a), .pos_v(pos_v_a),
    .hsync(hsync_a), .vsync(vsync_a), .blank(blank_a), .frame_tick(frame_tick_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .pix_tick(pix_tick_b), .pos_h(pos_h_b), .pos_v(pos_v_b),
    .hsync(hsync_b), .vsync(vsync_b), .blank(blank_b), .frame_tick(frame_tick_b)
  );

  tparam_t pa, pb;
  mstate_t ma, mb;
  int n_pass = 0;
  int n_total = 0;

  function automatic int htot(tparam_t p);
    return p.ha + p.hf + p.hs + p.hb;
  endfunction

  function automatic int vtot(tparam_t p);
    return p.va + p.vf + p.vs + p.vb;
  endfunction

  // Reference raster: position advances on pixel strobes and wraps at the totals
  function automatic mstate_t model_next(mstate_t s, tparam_t p, bit r);
    mstate_t n = s;
    if (r) begin
      n.h = 0; n.v = 0; n.ph = 1'b0;
      return n;
    end
    if (!DIV || s.ph) begin
      n.h = s.h + 1;
      if (n.h == htot(p)) begin
        n.h = 0;
        n.v = s.v + 1;
        if (n.v == vtot(p)) n.v = 0;
      end
    end
    n.ph = DIV ? !s.ph : 1'b0;
    return n;
  endfunction

  // {pix_tick, pos_h, pos_v, hsync, vsync, blank, frame_tick} implied by a position
  function automatic logic [24:0] exp_vec(mstate_t s, tparam_t p);
    logic hs, vs, bl, ft, pt;
    hs = (s.h >= p.ha + p.hf && s.h < p.ha + p.hf + p.hs) ? p.pol : !p.pol;
    vs = (s.v >= p.va + p.vf && s.v < p.va + p.vf + p.vs) ? p.pol : !p.pol;
    bl = (s.h >= p.ha) || (s.v >= p.va);
    ft = (s.h == 0) && (s.v == p.va);
    pt = DIV ? s.ph : 1'b1;
    return {pt, 10'(s.h), 10'(s.v), hs, vs, bl, ft};
  endfunction

  task automatic step();
    bit ra = rst_a;
    bit rb = rst_b;
    @(posedge clk);
    ma = model_next(ma, pa, ra);
    mb = model_next(mb, pb, rb);
    #1;
  endtask

  task automatic test_reset();
    int n;
    int steps;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) step();
    n_total++;
    if ({pos_h_a, pos_v_a, blank_a, hsync_a, vsync_a, frame_tick_a} !==
        {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      $display("FAIL reset_values got h=%0d v=%0d bl=%b hs=%b vs=%b ft=%b want 0 0 0 1 1 0",
               pos_h_a, pos_v_a, blank_a, hsync_a, vsync_a, frame_tick_a);
    end else n_pass++;
    n_total++;
    if (pix_tick_a !== !DIV) $display("FAIL reset_pix_tick got %b want %b", pix_tick_a, !DIV);
    else n_pass++;

    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        rst_a = 1'b0; rst_b = 1'b0;
      end else begin
        n = $urandom_range(200, 2500);
        repeat (n) step();
        rst_a = 1'b1;
        step();
        n_total++;
        if ({pos_h_a, pos_v_a, blank_a, hsync_a, frame_tick_a} !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b0})
          $display("FAIL midframe_reset_first_edge after %0d cycles got h=%0d v=%0d bl=%b hs=%b ft=%b want 0 0 0 1 0",
                   n, pos_h_a, pos_v_a, blank_a, hsync_a, frame_tick_a);
        else n_pass++;
        step(); step();
        n_total++;
        if ({pos_h_a, pos_v_a, vsync_a} !== {10'd0, 10'd0, 1'b1})
          $display("FAIL midframe_reset_hold got h=%0d v=%0d vs=%b want 0 0 1", pos_h_a, pos_v_a, vsync_a);
        else n_pass++;
        rst_a = 1'b0;
      end
      steps = 0;
      while (pos_h_a == 10'd0 && steps < 4) begin
        step();
        steps++;
      end
      n_total++;
      if (pos_h_a !== 10'd1 || pos_v_a !== 10'd0 || steps != (DIV ? 2 : 1))
        $display("FAIL first_pixel_after_release got h=%0d v=%0d after %0d cycles want h=1 v=0 after %0d",
                 pos_h_a, pos_v_a, steps, DIV ? 2 : 1);
      else n_pass++;
    end
  endtask

  task automatic test_line_timing();
    int prev_h = -1;
    int prev_v = 0;
    int first_blank = -1;
    int hs_first = -1;
    int hs_low = 0;
    bit done = 1'b0;
    bit vinc_ok = 1'b0;
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      if (int'(pos_h_a) != prev_h) begin
        if (int'(pos_v_a) != prev_v) begin
          done = 1'b1;
          vinc_ok = (prev_h == 799) && (pos_h_a == 10'd0) && (pos_v_a == 10'd1);
        end else begin
          if (blank_a && first_blank < 0) first_blank = int'(pos_h_a);
          if (!hsync_a) begin
            hs_low++;
            if (hs_first < 0) hs_first = int'(pos_h_a);
          end
        end
        prev_h = int'(pos_h_a);
        prev_v = int'(pos_v_a);
      end
      if (!done) step();
    end
    n_total++;
    if (!done) $display("FAIL line_end_timeout got last h=%0d v=%0d want v=1 within 2000 cycles", pos_h_a, pos_v_a);
    else n_pass++;
    n_total++;
    if (first_blank != 640) $display("FAIL blank_rise got h=%0d want 640", first_blank);
    else n_pass++;
    n_total++;
    if (hs_first != 656) $display("FAIL hsync_start got h=%0d want 656", hs_first);
    else n_pass++;
    n_total++;
    if (hs_low != 96) $display("FAIL hsync_width got %0d want 96", hs_low);
    else n_pass++;
    n_total++;
    if (!vinc_ok) $display("FAIL v_increment got h=%0d v=%0d (prev h=%0d) want 799->0 with v=1",
                           pos_h_a, pos_v_a, prev_h);
    else n_pass++;
  endtask

  task automatic test_alignment_random();
    int ra_left = 0;
    int rb_left = 0;
    logic [24:0] got, exp;
    for (int i = 0; i < 4000; i++) begin
      if (ra_left == 0 && $urandom_range(0, 499) == 0) ra_left = $urandom_range(1, 3);
      if (rb_left == 0 && $urandom_range(0, 299) == 0) rb_left = $urandom_range(1, 3);
      rst_a = (ra_left > 0);
      rst_b = (rb_left > 0);
      if (ra_left > 0) ra_left--;
      if (rb_left > 0) rb_left--;
      step();
      got = {pix_tick_a, pos_h_a, pos_v_a, hsync_a, vsync_a, blank_a, frame_tick_a};
      exp = exp_vec(ma, pa);
      n_total++;
      if (got !== exp) $display("FAIL align_a cycle %0d got %h want %h", i, got, exp);
      else n_pass++;
      got = {pix_tick_b, pos_h_b, pos_v_b, hsync_b, vsync_b, blank_b, frame_tick_b};
      exp = exp_vec(mb, pb);
      n_total++;
      if (got !== exp) $display("FAIL align_b cycle %0d got %h want %h", i, got, exp);
      else n_pass++;
    end
    rst_a = 1'b0; rst_b = 1'b0;
  endtask

  task automatic test_frame_small();
    int pix_per_frame = htot(pb) * vtot(pb);
    int npix = 0;
    int prev_h = -1;
    int prev_v = -1;
    int vs_cnt = 0;
    int ft_cnt = 0;
    int ft_bad = 0;
    int max_h = 0;
    int max_v = 0;
    int wraps = 0;
    int wrap_bad = 0;
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    for (int c = 0; c < 3000 && npix <= 3 * pix_per_frame; c++) begin
      if (int'(pos_h_b) != prev_h || int'(pos_v_b) != prev_v) begin
        npix++;
        if (prev_h == htot(pb) - 1 && prev_v == vtot(pb) - 1) begin
          wraps++;
          if (pos_h_b != 10'd0 || pos_v_b != 10'd0 || blank_b !== 1'b0) wrap_bad++;
        end
        if (npix <= 3 * pix_per_frame) begin
          if (vsync_b === pb.pol) vs_cnt++;
          if (frame_tick_b) begin
            ft_cnt++;
            if (pos_h_b != 10'd0 || int'(pos_v_b) != pb.va) ft_bad++;
          end
          if (int'(pos_h_b) > max_h) max_h = int'(pos_h_b);
          if (int'(pos_v_b) > max_v) max_v = int'(pos_v_b);
        end
        prev_h = int'(pos_h_b);
        prev_v = int'(pos_v_b);
      end
      if (npix <= 3 * pix_per_frame) step();
    end
    n_total++;
    if (npix != 3 * pix_per_frame + 1 || pos_h_b !== 10'd0 || pos_v_b !== 10'd0)
      $display("FAIL frame_return got %0d pixels ending at (%0d,%0d) want %0d ending at (0,0)",
               npix, pos_h_b, pos_v_b, 3 * pix_per_frame + 1);
    else n_pass++;
    n_total++;
    if (vs_cnt != 3 * pb.vs * htot(pb)) $display("FAIL vsync_width got %0d want %0d", vs_cnt, 3 * pb.vs * htot(pb));
    else n_pass++;
    n_total++;
    if (ft_cnt != 3 || ft_bad != 0) $display("FAIL frame_tick_count got %0d (misplaced %0d) want 3 (0)", ft_cnt, ft_bad);
    else n_pass++;
    n_total++;
    if (max_h != htot(pb) - 1 || max_v != vtot(pb) - 1)
      $display("FAIL counter_range got max (%0d,%0d) want (%0d,%0d)", max_h, max_v, htot(pb) - 1, vtot(pb) - 1);
    else n_pass++;
    n_total++;
    if (wraps != 3 || wrap_bad != 0) $display("FAIL frame_wrap got %0d wraps (%0d bad) want 3 (0)", wraps, wrap_bad);
    else n_pass++;
  endtask

  task automatic test_pix_tick();
    logic        pt_before;
    logic [23:0] out_before;
    int          hi = 0;
    bit          found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      pt_before  = pix_tick_a;
      out_before = {pos_h_a, pos_v_a, hsync_a, vsync_a, blank_a, frame_tick_a};
      step();
      n_total++;
      if (pix_tick_a !== (DIV ? !pt_before : 1'b1))
        $display("FAIL pix_tick_pattern got %b after %b want %b", pix_tick_a, pt_before, DIV ? !pt_before : 1'b1);
      else n_pass++;
      if (!pt_before) begin
        n_total++;
        if ({pos_h_a, pos_v_a, hsync_a, vsync_a, blank_a, frame_tick_a} !== out_before)
          $display("FAIL hold_without_tick got %h want %h",
                   {pos_h_a, pos_v_a, hsync_a, vsync_a, blank_a, frame_tick_a}, out_before);
        else n_pass++;
      end
    end
    for (int c = 0; c < 2000 && !found; c++) begin
      if (frame_tick_b) found = 1'b1;
      else step();
    end
    while (found && frame_tick_b && hi < 10) begin
      hi++;
      step();
    end
    n_total++;
    if (!found || hi != (DIV ? 2 : 1))
      $display("FAIL frame_tick_width got %0d cycles (found=%b) want %0d", hi, found, DIV ? 2 : 1);
    else n_pass++;
  endtask

  initial begin
    pa = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    pb = '{10, 2, 3, 2, 6, 2, 2, 3, 1'b1};
    ma = '{0, 0, 1'b0};
    mb = '{0, 0, 1'b0};
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    test_reset();
    test_line_timing();
    test_alignment_random();
    test_frame_small();
    test_pix_tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing: hsync, vsync, blank, and the beam position pos_h/pos_v.
- Drives every pixel-colour block in the Pong design: field, paddles, ball, score.
- Also emits a once-per-frame tick so game-state logic can update during vertical blanking.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync asserted level (0 = active-low)

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  synchronous, active-high reset
- pix_tick  out  1  pixel-advance strobe (constant 1 unless CLK_DIV_EN)
- pos_h  out  10  horizontal beam position, 0..H_TOTAL-1
- pos_v  out  10  vertical beam position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level per SYNC_POL
- vsync  out  1  vertical sync, level per SYNC_POL
- blank  out  1  1 = beam outside the visible 640x480 area
- frame_tick  out  1  one-pixel pulse at the start of vertical blank

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Totals: H_TOTAL = 800, V_TOTAL = 525. Counters are 10-bit unsigned and never exceed TOTAL-1.
- Advance: the counters advance only on cycles with pix_tick=1. With pix_tick=0, every output holds its value.
- Horizontal wrap: pos_h increments. When pos_h=799, it wraps to 0 and pos_v increments.
- Frame wrap: at pos_v=524 and pos_h=799, both counters return to 0 on the same edge.
- Horizontal phases: ACTIVE [0,640), FRONT [640,656), SYNC [656,752), BACK [752,800).
- Vertical phases: ACTIVE [0,480), FRONT [480,490), SYNC [490,492), BACK [492,525).
- hsync = SYNC_POL when pos_h is in the horizontal SYNC phase, otherwise ~SYNC_POL. vsync follows the same rule on pos_v.
- blank = (pos_h >= 640) || (pos_v >= 480).
- frame_tick = 1 for exactly one pix_tick period, while pos_h=0 and pos_v=480; otherwise 0.
- Alignment: all outputs are registered and consistent with the current pos_h/pos_v on every cycle, with no cycle of skew. hsync, vsync, blank and frame_tick are registered decodes of the next count.
- Reset values: pos_h=0, pos_v=0, blank=0, hsync=vsync=~SYNC_POL, frame_tick=0, divider phase=0.
- Reset mid-frame: all outputs reach their reset values on the first edge with rst=1 and hold while rst=1. On the first edge with rst=0 (and pix_tick=1), the counter advances to pos_h=1.
- Invariants: no combinational path from any input to any output. Parameters must satisfy totals <= 1023.

Optional Feature:
- Macro: CLK_DIV_EN.
- Defined: clk is 50 MHz. An internal 1-bit phase register toggles every cycle (0 after reset), and pix_tick = phase. Counters and outputs therefore update every second clk, giving a 25 MHz pixel rate. frame_tick still lasts one pix_tick period, i.e. two clk cycles.
- Undefined: clk is the 25 MHz pixel clock and pix_tick is tied to 1.
- The port list is identical in both builds.

Decomposition:
- Shared package vga_pkg holds:
  - the 640x480@60 timing constants;
  - H_TOTAL/V_TOTAL;
  - the phase-boundary constants (656, 752, 490, 492);
  - the 10-bit coord_t typedef, reused by field and the sprite blocks.
- Sub-module mod_counter: a generic modulo-N counter with enable input, wrap output and synchronous reset. It is instantiated twice: horizontal with en=pix_tick; vertical with en=pix_tick && h_wrap.

Test Plan:
- Reset: hold rst=1 for 3 cycles mid-frame at pos=(300,200) -> pos=(0,0), blank=0, hsync=vsync=1, frame_tick=0. First pixel after release: pos_h=1.
- Line timing: run 800 pix_ticks from (0,0) -> blank rises at pos_h=640; hsync low for exactly 96 ticks starting at pos_h=656; pos_v becomes 1 exactly at pos_h 799->0.
- Frame timing: run 420000 pix_ticks -> vsync low for exactly 1600 ticks (lines 490-491); frame_tick pulses exactly once, at (0,480); counters return to (0,0).
- Wrap boundary: at (799,524), the next tick gives (0,0) with blank=0, and pos_v never reads 525.
- CLK_DIV_EN build: run 1600 clk cycles from reset -> exactly one line; pix_tick alternates 0,1; outputs change only on pix_tick=1 edges; frame_tick is high for 2 clk cycles.
- Alignment check, every cycle over a full frame: blank == (pos_h>=640 || pos_v>=480) and hsync == !(656<=pos_h<752), with zero-cycle skew.
